// File: rtl/msrv32_wb_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_wb_pkg
// Shared definitions for the writeback retire unit:
//   - writeback source select codes (index into the packed source bus)
//   - the retire-queue entry record {rd, wr_en, data, pending}
//   - a small helper that classifies a select code as legal or not
// ----------------------------------------------------------------------------
package msrv32_wb_pkg;

    // Writeback source select codes; the code is also the slot index in
    // the packed source bus.
    localparam int WB_ALU     = 0;
    localparam int WB_LU      = 1;
    localparam int WB_IMM     = 2;
    localparam int WB_IADDER  = 3;
    localparam int WB_CSR     = 4;
    localparam int WB_PC_PLUS = 5;

    localparam int WB_NUM_SRC = 6;
    localparam int WB_XLEN    = 32;

    // One retire-queue entry at the default datapath width. pending marks a
    // load whose data has not come back yet.
    typedef struct packed {
        logic [4:0]         rd;
        logic               wr_en;
        logic [WB_XLEN-1:0] data;
        logic               pending;
    } wb_entry_t;

    // A select code is legal when it addresses one of the num_src sources.
    function automatic logic wb_sel_is_legal(input int unsigned sel,
                                             input int unsigned num_src);
        return (sel < num_src) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/msrv32_wb_retire_fifo.sv
// ----------------------------------------------------------------------------
// msrv32_wb_retire_fifo
// In-order retire queue of DEPTH entries. Keeps head (read), tail (write)
// pointers and an occupancy count, and locates the oldest pending load
// entry so returning load data can be written into it.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop every entry; overrides push/pop/fill this cycle
//   push, push_*     write a new entry at the tail (caller ensures !full)
//   pop              drop the head entry (caller ensures head is retirable)
//   fill_req/data    load data return; lands in the oldest pending entry
//   head_*           fields of the head entry, head_valid = queue non-empty
//   full             count == DEPTH
//   ld_found         an eligible pending entry exists for fill_req
// ----------------------------------------------------------------------------
module msrv32_wb_retire_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [4:0]       push_rd,
    input  logic             push_wr_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_pending,
    input  logic             pop,
    input  logic             fill_req,
    input  logic [WIDTH-1:0] fill_data,
    output logic             head_valid,
    output logic             head_pending,
    output logic [4:0]       head_rd,
    output logic             head_wr_en,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             ld_found
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [4:0]       rd_q_r      [DEPTH];
    logic             wr_en_q_r   [DEPTH];
    logic [WIDTH-1:0] data_q_r    [DEPTH];
    logic             pending_q_r [DEPTH];

    logic [PTR_W-1:0] ld_idx_s;
    logic             ld_found_s;

    // Load pointer: scan from the head for the oldest live pending entry.
    // Entries pushed this cycle are not in storage yet, so a load becomes
    // eligible for data only from the cycle after it was accepted.
    always_comb begin
        ld_found_s = 1'b0;
        ld_idx_s   = rd_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ld_found_s && (CNT_W'(i) < count_r)
                && pending_q_r[rd_ptr_r + PTR_W'(i)]) begin
                ld_found_s = 1'b1;
                ld_idx_s   = rd_ptr_r + PTR_W'(i);
            end else begin
                ld_found_s = ld_found_s;
            end
        end
    end

    // Queue storage, pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q_r[i]      <= 5'd0;
                wr_en_q_r[i]   <= 1'b0;
                data_q_r[i]    <= '0;
                pending_q_r[i] <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pending_q_r[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                rd_q_r[wr_ptr_r]      <= push_rd;
                wr_en_q_r[wr_ptr_r]   <= push_wr_en;
                data_q_r[wr_ptr_r]    <= push_data;
                pending_q_r[wr_ptr_r] <= push_pending;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            // The tail slot is never live, so a fill cannot collide with push.
            if (fill_req && ld_found_s) begin
                data_q_r[ld_idx_s]    <= fill_data;
                pending_q_r[ld_idx_s] <= 1'b0;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_valid   = (count_r != '0);
    assign head_pending = pending_q_r[rd_ptr_r];
    assign head_rd      = rd_q_r[rd_ptr_r];
    assign head_wr_en   = wr_en_q_r[rd_ptr_r];
    assign head_data    = data_q_r[rd_ptr_r];
    assign full         = (count_r == CNT_W'(DEPTH));
    assign ld_found     = ld_found_s;

endmodule

// File: rtl/msrv32_wb_retire_unit.sv
// ----------------------------------------------------------------------------
// msrv32_wb_retire_unit
// Buffered writeback stage between execute and the integer register file.
// Selects the writeback value from NUM_SRC packed sources, queues results in
// order (up to DEPTH), holds loads until the load unit returns data, and
// retires one register-file write per cycle. Also hosts the ALU second
// operand mux.
//
// Ports:
//   ms_riscv32_mp_clk_in/rst_in   clock, synchronous active-high reset
//   flush_in                      discard every queued entry
//   wb_valid_in / wb_ready_out    upstream handshake (ready = !full && !rst)
//   wb_mux_sel_in, rd_addr_in, rf_wr_en_in, src_data_in   result to queue
//   alu_src_in, imm_in, rs2_in -> alu_2nd_src_mux_out     (combinational)
//   lu_valid_in, lu_data_in       load data return
//   rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out         registered RF write
//   illegal_sel_out, lu_orphan_out                      1-cycle error pulses
// ----------------------------------------------------------------------------
module msrv32_wb_retire_unit
    import msrv32_wb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int SEL_W   = 3,
    parameter int LU_SEL  = WB_LU,
    parameter int DEPTH   = 4
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_in,
    input  logic                     flush_in,
    input  logic                     wb_valid_in,
    output logic                     wb_ready_out,
    input  logic [SEL_W-1:0]         wb_mux_sel_in,
    input  logic [4:0]               rd_addr_in,
    input  logic                     rf_wr_en_in,
    input  logic [NUM_SRC*WIDTH-1:0] src_data_in,
    input  logic                     alu_src_in,
    input  logic [WIDTH-1:0]         imm_in,
    input  logic [WIDTH-1:0]         rs2_in,
    output logic [WIDTH-1:0]         alu_2nd_src_mux_out,
    input  logic                     lu_valid_in,
    input  logic [WIDTH-1:0]         lu_data_in,
    output logic                     rf_wr_en_out,
    output logic [4:0]               rf_rd_addr_out,
    output logic [WIDTH-1:0]         rf_wr_data_out,
    output logic                     illegal_sel_out,
    output logic                     lu_orphan_out
);

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_legal_s;
    logic             is_load_s;
    logic             push_s;
    logic             pop_s;
    logic             fill_req_s;

    logic             head_valid_s;
    logic             head_pending_s;
    logic [4:0]       head_rd_s;
    logic             head_wr_en_s;
    logic [WIDTH-1:0] head_data_s;
    logic             full_s;
    logic             ld_found_s;

    // Writeback source select; out-of-range codes yield zero data.
    always_comb begin
        sel_data_s  = '0;
        sel_legal_s = wb_sel_is_legal(int'(wb_mux_sel_in), NUM_SRC);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(wb_mux_sel_in) == k) begin
                sel_data_s = src_data_in[k*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    assign is_load_s    = sel_legal_s && (int'(wb_mux_sel_in) == LU_SEL);
    assign wb_ready_out = !full_s && !ms_riscv32_mp_rst_in;
    assign push_s       = wb_valid_in && wb_ready_out && !flush_in;
    // Only a head whose data is already stored may retire: no fill bypass.
    assign pop_s        = head_valid_s && !head_pending_s && !flush_in;
    assign fill_req_s   = lu_valid_in && !flush_in;

    assign alu_2nd_src_mux_out = alu_src_in ? rs2_in : imm_in;

    msrv32_wb_retire_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (ms_riscv32_mp_clk_in),
        .rst          (ms_riscv32_mp_rst_in),
        .flush        (flush_in),
        .push         (push_s),
        .push_rd      (rd_addr_in),
        .push_wr_en   (rf_wr_en_in && sel_legal_s),
        .push_data    (is_load_s ? '0 : sel_data_s),
        .push_pending (is_load_s),
        .pop          (pop_s),
        .fill_req     (fill_req_s),
        .fill_data    (lu_data_in),
        .head_valid   (head_valid_s),
        .head_pending (head_pending_s),
        .head_rd      (head_rd_s),
        .head_wr_en   (head_wr_en_s),
        .head_data    (head_data_s),
        .full         (full_s),
        .ld_found     (ld_found_s)
    );

    // Registered register-file write port and error pulses.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rf_wr_en_out    <= 1'b0;
            rf_rd_addr_out  <= 5'd0;
            rf_wr_data_out  <= '0;
            illegal_sel_out <= 1'b0;
            lu_orphan_out   <= 1'b0;
        end else begin
            illegal_sel_out <= push_s && !sel_legal_s;
            lu_orphan_out   <= fill_req_s && !ld_found_s;
            if (pop_s) begin
                // x0 is hard-wired zero, so a retire to it never writes.
                rf_wr_en_out   <= head_wr_en_s && (head_rd_s != 5'd0);
                rf_rd_addr_out <= head_rd_s;
                rf_wr_data_out <= head_data_s;
            end else begin
                rf_wr_en_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msrv32_wb_retire_unit.sv
module tb_msrv32_wb_retire_unit;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [SEL_W-1:0]         sel;
    logic [4:0]               rd_addr;
    logic                     rf_we_in;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     alu_src;
    logic [WIDTH-1:0]         imm;
    logic [WIDTH-1:0]         rs2;
    logic [WIDTH-1:0]         alu_mux;
    logic                     lu_valid;
    logic [WIDTH-1:0]         lu_data;
    logic                     rf_we;
    logic [4:0]               rf_rd;
    logic [WIDTH-1:0]         rf_data;
    logic                     ill;
    logic                     orph;

    int pass_cnt = 0;
    int total_cnt = 0;

    msrv32_wb_retire_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .flush_in             (flush),
        .wb_valid_in          (wb_valid),
        .wb_ready_out         (wb_ready),
        .wb_mux_sel_in        (sel),
        .rd_addr_in           (rd_addr),
        .rf_wr_en_in          (rf_we_in),
        .src_data_in          (src_data),
        .alu_src_in           (alu_src),
        .imm_in               (imm),
        .rs2_in               (rs2),
        .alu_2nd_src_mux_out  (alu_mux),
        .lu_valid_in          (lu_valid),
        .lu_data_in           (lu_data),
        .rf_wr_en_out         (rf_we),
        .rf_rd_addr_out       (rf_rd),
        .rf_wr_data_out       (rf_data),
        .illegal_sel_out      (ill),
        .lu_orphan_out        (orph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic        luv;
        logic [31:0] lud;
        logic        fl;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_ill;
        logic        e_orph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [4:0] r,
                                input logic luv, input logic [31:0] lud, input logic fl,
                                input logic e_rdy, input logic e_we, input logic [4:0] e_rd,
                                input logic [31:0] e_data, input logic e_ill, input logic e_orph);
        vec_t t;
        t.v = v; t.sel = s; t.rd = r; t.luv = luv; t.lud = lud; t.fl = fl;
        t.e_rdy = e_rdy; t.e_we = e_we; t.e_rd = e_rd; t.e_data = e_data;
        t.e_ill = e_ill; t.e_orph = e_orph;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic chk_regs(input string tag, input logic we, input logic [4:0] r,
                            input logic [31:0] d, input logic i, input logic o);
        chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
        chk({tag, "_rd"}, {27'd0, rf_rd}, {27'd0, r});
        chk({tag, "_data"}, rf_data, d);
        chk({tag, "_ill"}, {31'd0, ill}, {31'd0, i});
        chk({tag, "_orph"}, {31'd0, orph}, {31'd0, o});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; sel = 3'd0; rd_addr = 5'd0;
        rf_we_in = 1'b1; alu_src = 1'b0; imm = 32'd30; rs2 = 32'd70;
        lu_valid = 1'b0; lu_data = 32'd0;
        src_data = {32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};

        // --- vector table: inputs, pre-edge ready, post-edge registered outputs
        // back-to-back non-load selects
        vecs.push_back(mk(1'b1, 3'd0, 5'd1, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd2, 5'd2, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd1, 32'd10,  1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd3, 5'd3, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd2, 32'd30,  1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd4, 5'd4, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd3, 32'd40,  1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd5, 5'd5, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd4, 32'd50,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd5, 32'd60,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        // load rd5, then ALU rd6 waits behind it
        vecs.push_back(mk(1'b1, 3'd1, 5'd5, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd0, 5'd6, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd20,  1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd5, 32'd20,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd6, 32'd10,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        // fill with 4 loads, 5th refused, in-order returns
        vecs.push_back(mk(1'b1, 3'd1, 5'd1, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd1, 5'd2, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd1, 5'd3, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd1, 5'd4, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd0, 5'd7, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd200, 1'b0, 1'b0, 1'b1, 5'd1, 32'd100, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd300, 1'b0, 1'b1, 1'b1, 5'd2, 32'd200, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd400, 1'b0, 1'b1, 1'b1, 5'd3, 32'd300, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd4, 32'd400, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        // rd=0 never writes; illegal select pulses and never writes
        vecs.push_back(mk(1'b1, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd7, 5'd3, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        // orphan load return on an empty queue
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd5,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        // three queued behind a load, then flush with push and lu_valid
        vecs.push_back(mk(1'b1, 3'd1, 5'd1, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd0, 5'd2, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd2, 5'd3, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd0, 5'd4, 1'b1, 32'd9,   1'b1, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b1, 32'd7,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 3'd5, 5'd9, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 5'd9, 32'd60,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd0, 5'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 1'b0));

        // --- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, wb_ready}, 32'd0);
        chk_regs("rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // --- table loop
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wb_valid = vecs[i].v;
            sel      = vecs[i].sel;
            rd_addr  = vecs[i].rd;
            lu_valid = vecs[i].luv;
            lu_data  = vecs[i].lud;
            flush    = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, wb_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_ill", i), {31'd0, ill}, {31'd0, vecs[i].e_ill});
            chk($sformatf("v%0d_orph", i), {31'd0, orph}, {31'd0, vecs[i].e_orph});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_rd", i), {27'd0, rf_rd}, {27'd0, vecs[i].e_rd});
                chk($sformatf("v%0d_data", i), rf_data, vecs[i].e_data);
            end
        end

        // --- idle output holds last written address/data
        @(negedge clk);
        wb_valid = 1'b0; lu_valid = 1'b0; flush = 1'b0;
        chk("hold_rd", {27'd0, rf_rd}, {27'd0, 5'd9});
        chk("hold_data", rf_data, 32'd60);

        // --- ALU second-operand mux, combinational
        alu_src = 1'b0; #1;
        chk("alu_imm", alu_mux, 32'd30);
        alu_src = 1'b1; #1;
        chk("alu_rs2", alu_mux, 32'd70);
        alu_src = 1'b0; #1;
        chk("alu_imm2", alu_mux, 32'd30);

        // --- reset mid-load discards the queue and clears outputs
        @(negedge clk);
        wb_valid = 1'b1; sel = 3'd1; rd_addr = 5'd5;
        @(negedge clk);
        sel = 3'd0; rd_addr = 5'd6;
        @(negedge clk);
        wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, wb_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk_regs("midrst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lu_valid = 1'b1; lu_data = 32'd55;
        #1;
        chk("postrst_ready", {31'd0, wb_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("postrst_orph", {31'd0, orph}, 32'd1);
        chk("postrst_we0", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst_idle%0d_we", k), {31'd0, rf_we}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
